// File: rtl/vm_change_dispenser.sv
// Coin hopper driver: queues change requests from the vending core and pays them out one coin
// at a time, retrying an eject on sensor timeout and latching a jam after the retries run out.
module vm_change_dispenser #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned EJECT_CYCLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    change_denomination_code,
    input  logic                          change_valid,
    input  logic                          coin_sensed,
    input  logic                          err_clear,
    output logic [3:0]                    hopper_sel,
    output logic                          hopper_eject,
    output logic                          coin_dispensed,
    output logic [3:0]                    dispensed_code,
    output logic                          dispense_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          jam_error,
    output logic                          overflow_error
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = $clog2(EJECT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EJECT,
        S_WAIT,
        S_JAM
    } state_t;

    state_t        state, state_d;
    logic [EW-1:0] eject_cnt, eject_cnt_d;
    logic [TW-1:0] timer, timer_d;
    logic [RW-1:0] retry_cnt, retry_cnt_d;
    logic          eject_d;
    logic          done_d;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] level_d;
    logic          full_c, empty_c, req_c, push_c, pop_c, drop_c, flush_c;

    // FIFO handshake; a pop frees a slot in the same cycle, so a full FIFO can still accept
    always_comb begin
        full_c  = (fifo_level == CW'(FIFO_DEPTH));
        empty_c = (fifo_level == '0);
        pop_c   = (state == S_IDLE) && !empty_c;
        req_c   = change_valid && (change_denomination_code != 4'h0);
        push_c  = req_c && (state != S_JAM) && (!full_c || pop_c);
        drop_c  = req_c && ((state == S_JAM) || (full_c && !pop_c));
        flush_c = (state_d == S_JAM) && (state != S_JAM);
        if (flush_c) begin
            level_d = '0;
        end else begin
            level_d = fifo_level + CW'(push_c) - CW'(pop_c);
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state;
        eject_cnt_d = eject_cnt;
        timer_d     = timer;
        retry_cnt_d = retry_cnt;
        eject_d     = 1'b0;
        done_d      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty_c) begin
                    state_d     = S_EJECT;
                    eject_cnt_d = '0;
                    retry_cnt_d = '0;
                end
            end
            S_EJECT: begin
                if (coin_sensed) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    eject_d = 1'b1;
                    if (eject_cnt == EW'(EJECT_CYCLES - 1)) begin
                        state_d = S_WAIT;
                        timer_d = '0;
                    end else begin
                        eject_cnt_d = eject_cnt + EW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (coin_sensed) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt + RW'(1);
                        eject_cnt_d = '0;
                        state_d     = S_EJECT;
                    end else begin
                        state_d = S_JAM;
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            S_JAM: begin
                if (err_clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            eject_cnt      <= '0;
            timer          <= '0;
            retry_cnt      <= '0;
            hopper_sel     <= 4'h0;
            hopper_eject   <= 1'b0;
            coin_dispensed <= 1'b0;
            dispensed_code <= 4'h0;
            dispense_busy  <= 1'b0;
            jam_error      <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            state          <= state_d;
            eject_cnt      <= eject_cnt_d;
            timer          <= timer_d;
            retry_cnt      <= retry_cnt_d;
            hopper_eject   <= eject_d;
            coin_dispensed <= done_d;
            dispense_busy  <= (level_d != '0) || (state_d != S_IDLE);
            if (pop_c) begin
                hopper_sel <= mem[rd_ptr];
            end
            if (done_d) begin
                dispensed_code <= hopper_sel;
            end
            // A new error event wins over a same-cycle clear
            if (flush_c) begin
                jam_error <= 1'b1;
            end else if (err_clear) begin
                jam_error <= 1'b0;
            end
            if (drop_c) begin
                overflow_error <= 1'b1;
            end else if (err_clear) begin
                overflow_error <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; entering JAM discards everything queued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush_c) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            fifo_level <= level_d;
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= change_denomination_code;
        end
    end

endmodule
